// File: rtl/control_unit.sv
// k_and_s_pkg: instruction encoding shared with data_path.
// control_unit: Moore FSM sequencing the K&S data_path through
//   fetch / decode / execute / write-back / branch / halt.
// Ports:
//   clk, rst                    clock, async active-high reset
//   decoded_instruction         instruction class from data_path
//   zero_op, neg_op             datapath flags (latched locally for branches)
//   unsigned_overflow,
//   signed_overflow             datapath flags, reserved (not used)
//   branch, pc_enable           PC load select / update strobe
//   ir_enable                   instruction register load
//   addr_sel                    RAM address select (1 = PC)
//   c_sel, operation            bus_c select, ALU op
//   write_reg_enable            register bank write
//   flags_reg_enable            datapath flag register update
//   ram_write_enable            RAM write strobe
//   halt                        processor stopped
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  localparam int WW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [WW-1:0] LAT = WW'(RD_LAT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD, S_STORE, S_MOVE,
    S_ALU, S_FLAGCAP, S_BRANCH, S_HALT
  } state_t;

  state_t                  state, nxt;
  logic [WW-1:0]           wcnt, wcnt_nxt;
  decoded_instruction_type op_q;
  logic                    z_q, n_q;
  logic                    done, take;

  // Overflow flags are reserved; folded here only so they are consumed.
  logic unused_ok;
  assign unused_ok = unsigned_overflow ^ signed_overflow;

  assign done = (wcnt == LAT);

  always_comb begin
    case (op_q)
      I_BRANCH: take = 1'b1;
      I_BZERO:  take = z_q;
      I_BNZERO: take = ~z_q;
      I_BNEG:   take = n_q;
      I_BNNEG:  take = ~n_q;
      default:  take = 1'b0;
    endcase
  end

  // Raw Moore outputs; gated by rst below so nothing leaks while in reset.
  logic       br_c, pc_c, ir_c, as_c, cs_c, wr_c, fe_c, rw_c, hl_c;
  logic [1:0] op_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      wcnt  <= '0;
      op_q  <= I_NOP;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      state <= nxt;
      wcnt  <= wcnt_nxt;
      if (state == S_DECODE) op_q <= decoded_instruction;
      // Datapath flag register clears when not enabled, so grab the ALU
      // result flags the cycle after the ALU write.
      if (state == S_FLAGCAP) begin
        z_q <= zero_op;
        n_q <= neg_op;
      end
    end
  end

  always_comb begin
    nxt      = state;
    wcnt_nxt = '0;
    br_c = 1'b0; pc_c = 1'b0; ir_c = 1'b0; as_c = 1'b0; cs_c = 1'b0;
    wr_c = 1'b0; fe_c = 1'b0; rw_c = 1'b0; hl_c = 1'b0; op_c = 2'b00;
    case (state)
      S_FETCH: begin
        as_c = 1'b1;
        if (done) begin
          ir_c = 1'b1;
          nxt  = S_DECODE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      // First fetch cycle overlapped with the flag capture; the count
      // carries into FETCH so ALU ops cost no extra cycle.
      S_FLAGCAP: begin
        as_c = 1'b1;
        if (done) begin
          ir_c = 1'b1;
          nxt  = S_DECODE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
          nxt      = S_FETCH;
        end
      end
      S_DECODE: begin
        pc_c = 1'b1;
        case (decoded_instruction)
          I_LOAD:   nxt = S_LOAD;
          I_STORE:  nxt = S_STORE;
          I_MOVE:   nxt = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR: nxt = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: nxt = S_BRANCH;
          I_HALT:   nxt = S_HALT;
          default:  nxt = S_FETCH;
        endcase
      end
      S_LOAD: begin
        if (done) begin
          cs_c = 1'b1;
          wr_c = 1'b1;
          nxt  = S_FETCH;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      S_STORE: begin
        rw_c = 1'b1;
        nxt  = S_FETCH;
      end
      S_MOVE: begin
        wr_c = 1'b1;
        nxt  = S_FETCH;
      end
      S_ALU: begin
        wr_c = 1'b1;
        fe_c = 1'b1;
        case (op_q)
          I_ADD:   op_c = 2'b01;
          I_SUB:   op_c = 2'b10;
          I_AND:   op_c = 2'b11;
          default: op_c = 2'b00;
        endcase
        nxt = S_FLAGCAP;
      end
      S_BRANCH: begin
        pc_c = take;
        br_c = take;
        nxt  = S_FETCH;
      end
      S_HALT: begin
        hl_c = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign branch           = ~rst & br_c;
  assign pc_enable        = ~rst & pc_c;
  assign ir_enable        = ~rst & ir_c;
  assign addr_sel         = ~rst & as_c;
  assign c_sel            = ~rst & cs_c;
  assign operation        = {2{~rst}} & op_c;
  assign write_reg_enable = ~rst & wr_c;
  assign flags_reg_enable = ~rst & fe_c;
  assign ram_write_enable = ~rst & rw_c;
  assign halt             = ~rst & hl_c;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: RD_LAT=1 and RD_LAT=2 instances share
// inputs; the driver queues the expected output word per cycle for one of
// them, the monitor pops and compares on the falling edge.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type instr = I_NOP;
  logic zero_op = 1'b0, neg_op = 1'b0, uovf = 1'b0, sovf = 1'b0;

  always #5 clk = ~clk;

  // {halt, ram_we, flags_en, wre, op[1:0], c_sel, addr_sel, ir, pc_en, branch}
  logic [10:0] o1, o2;

  control_unit #(.RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(uovf), .signed_overflow(sovf),
    .branch(o1[0]), .pc_enable(o1[1]), .ir_enable(o1[2]), .addr_sel(o1[3]),
    .c_sel(o1[4]), .operation(o1[6:5]), .write_reg_enable(o1[7]),
    .flags_reg_enable(o1[8]), .ram_write_enable(o1[9]), .halt(o1[10]));

  control_unit #(.RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(uovf), .signed_overflow(sovf),
    .branch(o2[0]), .pc_enable(o2[1]), .ir_enable(o2[2]), .addr_sel(o2[3]),
    .c_sel(o2[4]), .operation(o2[6:5]), .write_reg_enable(o2[7]),
    .flags_reg_enable(o2[8]), .ram_write_enable(o2[9]), .halt(o2[10]));

  localparam logic [10:0] Z     = 11'h000;
  localparam logic [10:0] AS    = 11'h008;  // fetch wait
  localparam logic [10:0] FIR   = 11'h00C;  // fetch + IR load
  localparam logic [10:0] DEC   = 11'h002;  // PC+1
  localparam logic [10:0] LDD   = 11'h090;  // load write-back
  localparam logic [10:0] ST    = 11'h200;
  localparam logic [10:0] MV    = 11'h080;
  localparam logic [10:0] A_ADD = 11'h1A0;
  localparam logic [10:0] A_SUB = 11'h1C0;
  localparam logic [10:0] A_AND = 11'h1E0;
  localparam logic [10:0] A_OR  = 11'h180;
  localparam logic [10:0] BRT   = 11'h003;
  localparam logic [10:0] HLT   = 11'h400;

  typedef struct {
    int          sel;
    logic [10:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      logic [10:0] act;
      it  = q.pop_front();
      act = (it.sel == 1) ? o1 : o2;
      vectors++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s (RD_LAT=%0d): got %03h expected %03h",
                 it.name, it.sel, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [10:0] e, input string n);
    item_t it;
    it.sel = sel; it.exp = e; it.name = n;
    q.push_back(it);
  endtask

  // Fetch on RD_LAT=1 that loads instruction i (decoded next cycle).
  task automatic fetch1(input decoded_instruction_type i);
    tick(); expect_out(1, AS, "fetch0");
    tick(); expect_out(1, FIR, "fetch1"); instr = i;
  endtask

  initial begin
    // ---------------- RD_LAT = 1 ----------------
    tick(); rst = 1'b1; expect_out(1, Z, "reset");
    tick(); expect_out(1, Z, "reset hold");
    tick(); rst = 1'b0; instr = I_LOAD; expect_out(1, AS, "post-reset fetch0");
    tick(); expect_out(1, FIR, "post-reset fetch1");
    tick(); expect_out(1, DEC, "decode load");
    tick(); rst = 1'b1; expect_out(1, Z, "rst mid-load");
    tick(); expect_out(1, Z, "rst mid-load hold");
    tick(); rst = 1'b0; expect_out(1, AS, "after rst fetch0");
    tick(); expect_out(1, FIR, "after rst ir"); instr = I_ADD;
    tick(); expect_out(1, DEC, "decode add");
    tick(); expect_out(1, A_ADD, "alu add");
    tick(); expect_out(1, AS, "flagcap");
    tick(); expect_out(1, FIR, "fetch after alu"); instr = I_SUB;
    tick(); expect_out(1, DEC, "decode sub");
    tick(); expect_out(1, A_SUB, "alu sub"); zero_op = 1'b1;
    tick(); expect_out(1, AS, "flagcap sub");
    tick(); zero_op = 1'b0; expect_out(1, FIR, "fetch nop"); instr = I_NOP;
    tick(); expect_out(1, DEC, "decode nop");
    fetch1(I_BZERO);
    tick(); expect_out(1, DEC, "decode bzero");
    tick(); expect_out(1, BRT, "bzero taken");
    fetch1(I_BNZERO);
    tick(); expect_out(1, DEC, "decode bnzero");
    tick(); expect_out(1, Z, "bnzero not taken");
    fetch1(I_AND);
    tick(); expect_out(1, DEC, "decode and");
    tick(); expect_out(1, A_AND, "alu and"); neg_op = 1'b1;
    tick(); expect_out(1, AS, "flagcap and");
    tick(); neg_op = 1'b0; expect_out(1, FIR, "fetch bnneg"); instr = I_BNNEG;
    tick(); expect_out(1, DEC, "decode bnneg");
    tick(); expect_out(1, Z, "bnneg not taken");
    fetch1(I_MOVE);
    tick(); expect_out(1, DEC, "decode move");
    tick(); expect_out(1, MV, "move");
    fetch1(I_BNEG);
    tick(); expect_out(1, DEC, "decode bneg");
    tick(); expect_out(1, BRT, "bneg taken after move");
    fetch1(I_OR);
    tick(); expect_out(1, DEC, "decode or");
    tick(); expect_out(1, A_OR, "alu or");
    tick(); expect_out(1, AS, "flagcap or");
    tick(); expect_out(1, FIR, "fetch bneg2"); instr = I_BNEG;
    tick(); expect_out(1, DEC, "decode bneg2");
    tick(); expect_out(1, Z, "bneg not taken after or");
    fetch1(decoded_instruction_type'(4'hF));
    tick(); expect_out(1, DEC, "decode illegal");
    fetch1(I_HALT);
    tick(); expect_out(1, DEC, "decode halt");
    for (int i = 0; i < 100; i++) begin
      tick();
      instr   = decoded_instruction_type'(4'($urandom_range(0, 15)));
      zero_op = 1'($urandom);
      neg_op  = 1'($urandom);
      expect_out(1, HLT, "halt held");
    end
    zero_op = 1'b0; neg_op = 1'b0;
    tick(); rst = 1'b1; expect_out(1, Z, "halt reset");
    tick(); rst = 1'b0; instr = I_LOAD; expect_out(1, AS, "halt release");

    // ---------------- RD_LAT = 2 ----------------
    tick(); rst = 1'b1; expect_out(2, Z, "reset2");
    tick(); rst = 1'b0; expect_out(2, AS, "f0");
    tick(); expect_out(2, AS, "f1");
    tick(); expect_out(2, FIR, "f2");
    tick(); expect_out(2, DEC, "decode load2");
    tick(); expect_out(2, Z, "load w0");
    tick(); expect_out(2, Z, "load w1");
    tick(); expect_out(2, LDD, "load wb");
    tick(); expect_out(2, AS, "f0b");
    tick(); expect_out(2, AS, "f1b");
    tick(); expect_out(2, FIR, "f2b"); instr = I_STORE;
    tick(); expect_out(2, DEC, "decode store");
    tick(); expect_out(2, ST, "store");
    tick(); expect_out(2, AS, "f0c");
    tick(); expect_out(2, AS, "f1c");
    tick(); expect_out(2, FIR, "f2c"); instr = I_ADD;
    tick(); expect_out(2, DEC, "decode add2");
    tick(); expect_out(2, A_ADD, "alu add2");
    tick(); expect_out(2, AS, "flagcap2");
    tick(); expect_out(2, AS, "fetch w1 continued");
    tick(); expect_out(2, FIR, "fetch w2 continued"); instr = I_NOP;
    tick(); expect_out(2, DEC, "decode nop2");
    tick(); expect_out(2, AS, "f0d");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
